// File: rtl/idex_pipe_stage.sv
// Decode-to-execute pipeline stage: main register M feeds execute, skid register S
// absorbs one extra entry so in_ready is a pure decode of held state. Optional IDEX_PERF_EN adds perf counters.
module idex_pipe_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 1,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CTRL_W = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         ctrl_in,
    input  logic [DATA_W*LANES-1:0]   srcA_in,
    input  logic [DATA_W*LANES-1:0]   srcB_in,
    input  logic [REG_AW-1:0]         rs1_in,
    input  logic [REG_AW-1:0]         rs2_in,
    input  logic [REG_AW-1:0]         rd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         ctrl_out,
    output logic [3:0]                aluop_ex,
    output logic [1:0]                wb_sel_ex,
    output logic                      mem_we_ex,
    output logic                      wre_ex,
    output logic                      vwre_ex,
    output logic                      load_ex,
    output logic [DATA_W*LANES-1:0]   srcA_out,
    output logic [DATA_W*LANES-1:0]   srcB_out,
    output logic [REG_AW-1:0]         rs1_ex,
    output logic [REG_AW-1:0]         rs2_ex,
    output logic [REG_AW-1:0]         rd_ex
`ifdef IDEX_PERF_EN
    ,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               flush_cnt
`endif
);

    typedef struct packed {
        logic [CTRL_W-1:0]       ctrl;
        logic [DATA_W*LANES-1:0] src_a;
        logic [DATA_W*LANES-1:0] src_b;
        logic [REG_AW-1:0]       rs1;
        logic [REG_AW-1:0]       rs2;
        logic [REG_AW-1:0]       rd;
    } entry_t;

    logic   m_valid;
    logic   s_valid;
    entry_t m_data;
    entry_t s_data;
    entry_t in_data;
    logic   acc;
    logic   cons;

    assign in_data  = '{ctrl: ctrl_in, src_a: srcA_in, src_b: srcB_in,
                        rs1: rs1_in, rs2: rs2_in, rd: rd_in};
    assign in_ready = !s_valid && !reset;
    assign acc      = in_valid && in_ready;
    assign cons     = m_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (flush) begin
            // Payloads are deliberately left intact; only the valid bits drop.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!m_valid || cons) begin
            if (s_valid) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (acc) begin
                m_data  <= in_data;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (acc) begin
            s_data  <= in_data;
            s_valid <= 1'b1;
        end
    end

    assign out_valid = m_valid;
    assign ctrl_out  = m_data.ctrl & {CTRL_W{m_valid}};
    assign aluop_ex  = ctrl_out[3:0];
    assign wb_sel_ex = ctrl_out[5:4];
    assign mem_we_ex = ctrl_out[6];
    assign wre_ex    = ctrl_out[7];
    assign vwre_ex   = ctrl_out[8];
    assign load_ex   = m_valid && (m_data.ctrl[5:4] == 2'b01);

    assign srcA_out  = m_data.src_a;
    assign srcB_out  = m_data.src_b;
    assign rs1_ex    = m_data.rs1;
    assign rs2_ex    = m_data.rs2;
    assign rd_ex     = m_data.rd;

`ifdef IDEX_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (m_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush && (m_valid || s_valid) && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Directed self-checking bench for idex_pipe_stage, built with four operand lanes.
module tb_idex_pipe_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned NL = 4;
    localparam int unsigned RW = 4;
    localparam int unsigned CW = 9;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CW-1:0]     ctrl_in;
    logic [DW*NL-1:0]  srcA_in, srcB_in;
    logic [RW-1:0]     rs1_in, rs2_in, rd_in;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     ctrl_out;
    logic [3:0]        aluop_ex;
    logic [1:0]        wb_sel_ex;
    logic              mem_we_ex, wre_ex, vwre_ex, load_ex;
    logic [DW*NL-1:0]  srcA_out, srcB_out;
    logic [RW-1:0]     rs1_ex, rs2_ex, rd_ex;
`ifdef IDEX_PERF_EN
    logic [15:0]       stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    idex_pipe_stage #(.DATA_W(DW), .LANES(NL), .REG_AW(RW), .CTRL_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .srcA_in(srcA_in), .srcB_in(srcB_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .aluop_ex(aluop_ex), .wb_sel_ex(wb_sel_ex),
        .mem_we_ex(mem_we_ex), .wre_ex(wre_ex), .vwre_ex(vwre_ex), .load_ex(load_ex),
        .srcA_out(srcA_out), .srcB_out(srcB_out),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex)
`ifdef IDEX_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [RW-1:0] d);
        in_valid = 1'b1;
        ctrl_in  = c;
        srcA_in  = {NL{a}};
        srcB_in  = {NL{~a}};
        rs1_in   = d + 4'd1;
        rs2_in   = d + 4'd2;
        rd_in    = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL reset_flags out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
            errors++;
        end
        checks++;
        if (ctrl_out !== 9'h000 || srcA_out !== 64'h0 || rd_ex !== 4'h0) begin
            $display("FAIL reset_payload ctrl=%h srcA=%h rd=%h want 0", ctrl_out, srcA_out, rd_ex);
            errors++;
        end
`ifdef IDEX_PERF_EN
        checks++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            $display("FAIL reset_perf stall=%h flush=%h want 0 0", stall_cnt, flush_cnt);
            errors++;
        end
`endif
        reset = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL post_reset in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
            errors++;
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        offer(9'h080, 16'h1234, 4'd1);
        step();
        checks++;
        if (out_valid !== 1'b1 || srcA_out !== {NL{16'h1234}} || rd_ex !== 4'd1 || wre_ex !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL stream_a v=%b srcA=%h rd=%0d wre=%b rdy=%b want 1 %h 1 1 1",
                     out_valid, srcA_out, rd_ex, wre_ex, in_ready, {NL{16'h1234}});
            errors++;
        end
        offer(9'h080, 16'h5678, 4'd2);
        step();
        checks++;
        if (out_valid !== 1'b1 || srcA_out !== {NL{16'h5678}} || srcB_out !== {NL{16'hA987}} || rd_ex !== 4'd2 || in_ready !== 1'b1) begin
            $display("FAIL stream_b v=%b srcA=%h srcB=%h rd=%0d rdy=%b", out_valid, srcA_out, srcB_out, rd_ex, in_ready);
            errors++;
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || wre_ex !== 1'b0 || ctrl_out !== 9'h000 || srcA_out !== {NL{16'h5678}}) begin
            $display("FAIL stream_bubble v=%b wre=%b ctrl=%h srcA=%h want 0 0 000 %h",
                     out_valid, wre_ex, ctrl_out, srcA_out, {NL{16'h5678}});
            errors++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(9'h080, 16'hAAAA, 4'd3);
        step();
        checks++;
        if (out_valid !== 1'b1 || srcA_out !== {NL{16'hAAAA}} || in_ready !== 1'b1) begin
            $display("FAIL bp_x v=%b srcA=%h rdy=%b want 1 AAAA.. 1", out_valid, srcA_out, in_ready);
            errors++;
        end
        offer(9'h080, 16'hBBBB, 4'd4);
        step();
        checks++;
        if (in_ready !== 1'b0 || srcA_out !== {NL{16'hAAAA}} || rd_ex !== 4'd3) begin
            $display("FAIL bp_hold rdy=%b srcA=%h rd=%0d want 0 AAAA.. 3", in_ready, srcA_out, rd_ex);
            errors++;
        end
        // Keep offering a third entry; it must not displace the skid entry.
        offer(9'h080, 16'hEEEE, 4'd9);
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || srcA_out !== {NL{16'hAAAA}}) begin
            $display("FAIL bp_full rdy=%b srcA=%h want 0 AAAA..", in_ready, srcA_out);
            errors++;
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || srcA_out !== {NL{16'hBBBB}} || rd_ex !== 4'd4 || in_ready !== 1'b1) begin
            $display("FAIL bp_drain_y v=%b srcA=%h rd=%0d rdy=%b want 1 BBBB.. 4 1", out_valid, srcA_out, rd_ex, in_ready);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp_empty v=%b rdy=%b want 0 1", out_valid, in_ready);
            errors++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(9'h0D0, 16'h1111, 4'd5);
        step();
        offer(9'h0D0, 16'h2222, 4'd6);
        step();
        checks++;
        if (in_ready !== 1'b0 || load_ex !== 1'b1 || mem_we_ex !== 1'b1 || wre_ex !== 1'b1) begin
            $display("FAIL flush_pre rdy=%b load=%b mwe=%b wre=%b want 0 1 1 1", in_ready, load_ex, mem_we_ex, wre_ex);
            errors++;
        end
        offer(9'h0D0, 16'hCCCC, 4'd7);
        flush = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || wre_ex !== 1'b0 || mem_we_ex !== 1'b0 || load_ex !== 1'b0 || in_ready !== 1'b1 || ctrl_out !== 9'h000) begin
            $display("FAIL flush_full v=%b wre=%b mwe=%b load=%b rdy=%b ctrl=%h want 0 0 0 0 1 000",
                     out_valid, wre_ex, mem_we_ex, load_ex, in_ready, ctrl_out);
            errors++;
        end
        checks++;
        if (srcA_out !== {NL{16'h1111}} || rd_ex !== 4'd5) begin
            $display("FAIL flush_payload srcA=%h rd=%0d want 1111.. 5", srcA_out, rd_ex);
            errors++;
        end
        // Flush into an empty, ready stage still drops the offered entry.
        offer(9'h0D0, 16'hDDDD, 4'd8);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || srcA_out !== {NL{16'h1111}}) begin
            $display("FAIL flush_empty v=%b srcA=%h want 0 1111..", out_valid, srcA_out);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL flush_ghost v=%b want 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ctrl_in   = 9'h11A;
        srcA_in   = 64'h4444_3333_2222_1111;
        srcB_in   = 64'h8888_7777_6666_5555;
        rs1_in    = 4'd5;
        rs2_in    = 4'd6;
        rd_in     = 4'd7;
        step();
        in_valid = 1'b0;
        checks++;
        if (load_ex !== 1'b1 || vwre_ex !== 1'b1 || aluop_ex !== 4'hA || wb_sel_ex !== 2'b01 ||
            wre_ex !== 1'b0 || mem_we_ex !== 1'b0 || ctrl_out !== 9'h11A) begin
            $display("FAIL decode_fields load=%b vwre=%b alu=%h wb=%b wre=%b mwe=%b ctrl=%h want 1 1 a 01 0 0 11a",
                     load_ex, vwre_ex, aluop_ex, wb_sel_ex, wre_ex, mem_we_ex, ctrl_out);
            errors++;
        end
        checks++;
        if (srcA_out !== 64'h4444_3333_2222_1111 || srcB_out !== 64'h8888_7777_6666_5555 ||
            rs1_ex !== 4'd5 || rs2_ex !== 4'd6 || rd_ex !== 4'd7) begin
            $display("FAIL decode_lanes srcA=%h srcB=%h rs1=%0d rs2=%0d rd=%0d", srcA_out, srcB_out, rs1_ex, rs2_ex, rd_ex);
            errors++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(9'h080, 16'h3333, 4'd2);
        step();
        offer(9'h080, 16'h4444, 4'd3);
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL rst_mid_pre rdy=%b v=%b want 0 1", in_ready, out_valid);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || srcA_out !== 64'h0 || wre_ex !== 1'b0) begin
            $display("FAIL rst_mid_during v=%b rdy=%b srcA=%h wre=%b want 0 0 0 0", out_valid, in_ready, srcA_out, wre_ex);
            errors++;
        end
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL rst_mid_after v=%b rdy=%b want 0 1", out_valid, in_ready);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL rst_mid_ghost v=%b want 0", out_valid);
            errors++;
        end
    endtask

`ifdef IDEX_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b0;
        offer(9'h080, 16'h5555, 4'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if (stall_cnt !== 16'd3) begin
            $display("FAIL perf_stall3 stall=%0d want 3", stall_cnt);
            errors++;
        end
        for (int i = 0; i < 70000; i++) step();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            $display("FAIL perf_stall_sat stall=%h want ffff", stall_cnt);
            errors++;
        end
        flush = 1'b1;
        step();
        checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'hFFFF) begin
            $display("FAIL perf_flush1 flush=%0d stall=%h want 1 ffff", flush_cnt, stall_cnt);
            errors++;
        end
        step();
        flush = 1'b0;
        checks++;
        if (flush_cnt !== 16'd1) begin
            $display("FAIL perf_flush_empty flush=%0d want 1", flush_cnt);
            errors++;
        end
    endtask
`endif

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ctrl_in = '0; srcA_in = '0; srcB_in = '0; rs1_in = '0; rs2_in = '0; rd_in = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_decode();
        test_reset_mid();
`ifdef IDEX_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
